// File: rtl/data_cache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
package data_cache_pkg;

  localparam int ADDR_W  = 8;
  localparam int BYTE_W  = 8;
  localparam int BLOCK_W = 32;
  localparam int MADDR_W = 6;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2
  } state_e;

  function automatic logic [BYTE_W-1:0] byte_sel(
    input logic [BLOCK_W-1:0] line,
    input logic [1:0]         off
  );
    return line[{off, 3'b000} +: BYTE_W];
  endfunction

endpackage

// File: rtl/data_cache_if.sv
// CPU load/store path and block-memory bus seen by the data cache.
interface data_cache_if;
  import data_cache_pkg::*;

  logic               READ;
  logic               WRITE;
  logic [ADDR_W-1:0]  ADDRESS;
  logic [BYTE_W-1:0]  WRITEDATA;
  logic [BYTE_W-1:0]  READDATA;
  logic               BUSYWAIT;
  logic               MEM_READ;
  logic               MEM_WRITE;
  logic [MADDR_W-1:0] MEM_ADDRESS;
  logic [BLOCK_W-1:0] MEM_WRITEDATA;
  logic [BLOCK_W-1:0] MEM_READDATA;
  logic               MEM_BUSYWAIT;

  modport slave (
    input  READ, WRITE, ADDRESS, WRITEDATA,
    input  MEM_READDATA, MEM_BUSYWAIT,
    output READDATA, BUSYWAIT,
    output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );

  modport master (
    output READ, WRITE, ADDRESS, WRITEDATA,
    output MEM_READDATA, MEM_BUSYWAIT,
    input  READDATA, BUSYWAIT,
    input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );

endinterface

// File: rtl/cache_line_array.sv
// Tag/valid/dirty/data storage: byte write, full-line fill, async read.
module cache_line_array
  import data_cache_pkg::*;
#(
  parameter int INDEX_BITS  = 3,
  parameter int OFFSET_BITS = 2,
  parameter int TAG_BITS    = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [INDEX_BITS-1:0]  idx_i,
  input  logic                   wr_en_i,
  input  logic [OFFSET_BITS-1:0] wr_off_i,
  input  logic [BYTE_W-1:0]      wr_byte_i,
  input  logic                   fill_en_i,
  input  logic [INDEX_BITS-1:0]  fill_idx_i,
  input  logic [TAG_BITS-1:0]    fill_tag_i,
  input  logic [BLOCK_W-1:0]     fill_data_i,
  output logic                   valid_o,
  output logic                   dirty_o,
  output logic [TAG_BITS-1:0]    tag_o,
  output logic [BLOCK_W-1:0]     data_o
);

  localparam int NLINES = 1 << INDEX_BITS;

  logic [NLINES-1:0]   valid_q;
  logic [NLINES-1:0]   dirty_q;
  logic [TAG_BITS-1:0] tag_q  [NLINES];
  logic [BLOCK_W-1:0]  data_q [NLINES];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en_i) begin
      valid_q[fill_idx_i] <= 1'b1;
      dirty_q[fill_idx_i] <= 1'b0;
    end else if (wr_en_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  // Payload storage carries no reset; valid bits gate every use.
  always_ff @(posedge clk_i) begin
    if (fill_en_i) begin
      tag_q[fill_idx_i]  <= fill_tag_i;
      data_q[fill_idx_i] <= fill_data_i;
    end else if (wr_en_i) begin
      data_q[idx_i][{wr_off_i, 3'b000} +: BYTE_W] <= wr_byte_i;
    end
  end

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign data_o  = data_q[idx_i];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate data cache with miss FSM.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int INDEX_BITS  = 3,
  parameter int OFFSET_BITS = 2
) (
  input  logic         CLK,
  input  logic         RESET,
  data_cache_if.slave  bus
);

  localparam int TAG_BITS = ADDR_W - INDEX_BITS - OFFSET_BITS;

  logic [TAG_BITS-1:0]    tag_a;
  logic [INDEX_BITS-1:0]  idx_a;
  logic [OFFSET_BITS-1:0] off_a;

  assign {tag_a, idx_a, off_a} = bus.ADDRESS;

  state_e                         state_q;
  logic [TAG_BITS+INDEX_BITS-1:0] req_q;
  logic                           mem_rd_q;
  logic                           mem_wr_q;
  logic [MADDR_W-1:0]             mem_addr_q;
  logic [BLOCK_W-1:0]             mem_wdata_q;

  logic                l_valid;
  logic                l_dirty;
  logic [TAG_BITS-1:0] l_tag;
  logic [BLOCK_W-1:0]  l_data;

  logic req;
  logic idle;
  logic hit;
  logic wr_hit;
  logic fill_en;

  assign req     = bus.READ | bus.WRITE;
  assign idle    = (state_q == IDLE);
  assign hit     = l_valid && (l_tag == tag_a);
  assign wr_hit  = idle && bus.WRITE && hit;
  assign fill_en = (state_q == FETCH) && !bus.MEM_BUSYWAIT;

  cache_line_array #(
    .INDEX_BITS  (INDEX_BITS),
    .OFFSET_BITS (OFFSET_BITS),
    .TAG_BITS    (TAG_BITS)
  ) u_lines (
    .clk_i       (CLK),
    .rst_ni      (RESET),
    .idx_i       (idx_a),
    .wr_en_i     (wr_hit),
    .wr_off_i    (off_a),
    .wr_byte_i   (bus.WRITEDATA),
    .fill_en_i   (fill_en),
    .fill_idx_i  (req_q[INDEX_BITS-1:0]),
    .fill_tag_i  (req_q[TAG_BITS+INDEX_BITS-1:INDEX_BITS]),
    .fill_data_i (bus.MEM_READDATA),
    .valid_o     (l_valid),
    .dirty_o     (l_dirty),
    .tag_o       (l_tag),
    .data_o      (l_data)
  );

  // Stall and load data are masked while reset is held.
  assign bus.BUSYWAIT = RESET && req && !(idle && hit);
  assign bus.READDATA = (RESET && bus.READ && idle && hit)
                      ? byte_sel(l_data, off_a) : '0;

  assign bus.MEM_READ      = mem_rd_q;
  assign bus.MEM_WRITE     = mem_wr_q;
  assign bus.MEM_ADDRESS   = mem_addr_q;
  assign bus.MEM_WRITEDATA = mem_wdata_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      req_q       <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req && !hit) begin
            req_q <= {tag_a, idx_a};
            if (l_valid && l_dirty) begin
              state_q     <= WRITEBACK;
              mem_wr_q    <= 1'b1;
              mem_addr_q  <= {l_tag, idx_a};
              mem_wdata_q <= l_data;
            end else begin
              state_q    <= FETCH;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= {tag_a, idx_a};
            end
          end
        end
        WRITEBACK: begin
          if (!bus.MEM_BUSYWAIT) begin
            state_q    <= FETCH;
            mem_wr_q   <= 1'b0;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= req_q;
          end
        end
        FETCH: begin
          if (!bus.MEM_BUSYWAIT) begin
            state_q  <= IDLE;
            mem_rd_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench: transaction-level cache model plus latency memory.
module tb_data_cache;
  import data_cache_pkg::*;

  localparam int LAT = 4;

  typedef struct packed {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
  } xfer_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  data_cache_if bus();

  data_cache dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [64];
  bit          inited = 1'b0;
  int          cnt    = 0;
  int          head   = 0;
  int          wb_cnt = 0;
  logic [31:0] last_wb   = '0;
  logic [5:0]  last_wb_a = '0;
  logic [5:0]  last_rd_a = '0;

  xfer_t       exp_q [$];
  bit          active = 1'b0;
  logic [7:0]  exp_rd = '0;

  bit          mvalid [8];
  bit          mdirty [8];
  logic [2:0]  mtag   [8];
  logic [31:0] mdata  [8];

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, act, exp);
    end
  endtask

  assign bus.MEM_BUSYWAIT = (bus.MEM_READ | bus.MEM_WRITE) && (cnt != LAT);
  assign bus.MEM_READDATA = mem[bus.MEM_ADDRESS];

  // Memory: busy for LAT cycles, completes on the following edge.
  always @(posedge clk) begin
    if (!inited) begin
      for (int i = 0; i < 64; i++)
        mem[i] <= {8'(i + 'h30), 8'(i + 'h20), 8'(i + 'h10), 8'(i)};
      mem[9] <= 32'hDDCCBBAA;
      inited <= 1'b1;
    end
    if (bus.MEM_READ || bus.MEM_WRITE) begin
      if (cnt == LAT) begin
        cnt <= 0;
        chk("xfer_expected", 32'(exp_q.size() > head), 1);
        head <= head + 1;
        if (bus.MEM_WRITE) begin
          mem[bus.MEM_ADDRESS] <= bus.MEM_WRITEDATA;
          last_wb   <= bus.MEM_WRITEDATA;
          last_wb_a <= bus.MEM_ADDRESS;
          wb_cnt    <= wb_cnt + 1;
        end else begin
          last_rd_a <= bus.MEM_ADDRESS;
        end
      end else begin
        cnt <= cnt + 1;
      end
    end else begin
      cnt <= 0;
    end
  end

  // Per-cycle compare against the transaction model.
  always @(negedge clk) begin
    if (active) begin
      int pend;
      pend = exp_q.size() - head;
      chk("strobe_excl", 32'(bus.MEM_READ & bus.MEM_WRITE), 0);
      chk("busywait", 32'(bus.BUSYWAIT),
          32'((bus.READ | bus.WRITE) && pend != 0));
      if (pend == 0) begin
        chk("idle_strobes", {bus.MEM_READ, bus.MEM_WRITE}, 0);
      end else if (bus.MEM_READ | bus.MEM_WRITE) begin
        chk("xfer_kind", 32'(bus.MEM_WRITE), 32'(exp_q[head].wr));
        chk("mem_addr", 32'(bus.MEM_ADDRESS), 32'(exp_q[head].addr));
        if (bus.MEM_WRITE)
          chk("mem_wdata", bus.MEM_WRITEDATA, exp_q[head].data);
      end
      if (bus.READ && !bus.WRITE && !bus.BUSYWAIT)
        chk("readdata", 32'(bus.READDATA), 32'(exp_rd));
    end
  end

  task automatic access(input bit r, input bit w, input logic [7:0] a,
                        input logic [7:0] d, output logic [7:0] got);
    logic [2:0] t;
    logic [2:0] ix;
    logic [1:0] o;
    int n;
    int stall;
    int est;
    bit done;
    t = a[7:5];
    ix = a[4:2];
    o = a[1:0];
    n = 0;
    stall = 0;
    done = 1'b0;
    got = '0;
    if (!(mvalid[ix] && mtag[ix] == t)) begin
      if (mvalid[ix] && mdirty[ix]) begin
        exp_q.push_back('{1'b1, {mtag[ix], ix}, mdata[ix]});
        n++;
      end
      exp_q.push_back('{1'b0, {t, ix}, 32'h0});
      n++;
      mdata[ix]  = mem[{t, ix}];
      mtag[ix]   = t;
      mvalid[ix] = 1'b1;
      mdirty[ix] = 1'b0;
    end
    exp_rd = mdata[ix][8*o +: 8];
    if (w) begin
      mdata[ix][8*o +: 8] = d;
      mdirty[ix] = 1'b1;
    end
    est = (n == 0) ? 0 : 1 + n * (LAT + 1);
    @(posedge clk); #1;
    bus.READ = r;
    bus.WRITE = w;
    bus.ADDRESS = a;
    bus.WRITEDATA = d;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (bus.BUSYWAIT) stall++;
      else begin
        done = 1'b1;
        got = bus.READDATA;
      end
    end
    chk($sformatf("timeout_%h", a), 32'(done), 1);
    @(posedge clk); #1;
    bus.READ = 1'b0;
    bus.WRITE = 1'b0;
    chk($sformatf("stall_%h", a), stall, est);
    chk($sformatf("pending_%h", a), exp_q.size() - head, 0);
  endtask

  initial begin
    logic [7:0] g;
    bus.READ = 1'b0;
    bus.WRITE = 1'b0;
    bus.ADDRESS = '0;
    bus.WRITEDATA = '0;
    for (int i = 0; i < 8; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
      mtag[i] = '0;
      mdata[i] = '0;
    end
    repeat (2) @(posedge clk);
    #2;
    bus.READ = 1'b1;
    bus.ADDRESS = 8'h25;
    #1;
    chk("rst_busy", 32'(bus.BUSYWAIT), 0);
    chk("rst_mread", 32'(bus.MEM_READ), 0);
    chk("rst_mwrite", 32'(bus.MEM_WRITE), 0);
    chk("rst_rdata", 32'(bus.READDATA), 0);
    chk("rst_maddr", 32'(bus.MEM_ADDRESS), 0);
    chk("rst_mwdata", bus.MEM_WRITEDATA, 0);
    bus.READ = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    active = 1'b1;

    access(1, 0, 8'h25, 8'h00, g);
    chk("cold_rd", 32'(g), 32'h BB);
    chk("cold_addr", 32'(last_rd_a), 32'h09);
    chk("cold_nowb", wb_cnt, 0);

    access(0, 1, 8'h26, 8'h5A, g);
    access(1, 0, 8'h26, 8'h00, g);
    chk("hit_rd", 32'(g), 32'h5A);

    access(1, 0, 8'h45, 8'h00, g);
    chk("wb_addr", 32'(last_wb_a), 32'h09);
    chk("wb_data", last_wb, 32'hDD5ABBAA);
    chk("evict_addr", 32'(last_rd_a), 32'h11);
    chk("evict_rd", 32'(g), 32'h21);

    access(1, 0, 8'h25, 8'h00, g);
    chk("clean_rd", 32'(g), 32'hBB);
    chk("clean_addr", 32'(last_rd_a), 32'h09);
    chk("clean_nowb", wb_cnt, 1);

    access(0, 1, 8'h0B, 8'h77, g);
    access(1, 0, 8'h0B, 8'h00, g);
    chk("alloc_rd", 32'(g), 32'h77);

    active = 1'b0;
    @(posedge clk); #1;
    bus.READ = 1'b1;
    bus.ADDRESS = 8'h85;
    for (int c = 0; c < 20 && !bus.MEM_READ; c++) @(negedge clk);
    chk("mid_fetch_started", 32'(bus.MEM_READ), 1);
    chk("mid_fetch_addr", 32'(bus.MEM_ADDRESS), 32'h21);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mread", 32'(bus.MEM_READ), 0);
    chk("mid_rst_mwrite", 32'(bus.MEM_WRITE), 0);
    chk("mid_rst_busy", 32'(bus.BUSYWAIT), 0);
    bus.READ = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    active = 1'b1;

    access(1, 0, 8'h25, 8'h00, g);
    chk("post_rst_rd", 32'(g), 32'hBB);

    access(1, 1, 8'h24, 8'h11, g);
    access(1, 0, 8'h24, 8'h00, g);
    chk("both_rd", 32'(g), 32'h11);
    access(1, 0, 8'h44, 8'h00, g);
    chk("both_wb_addr", 32'(last_wb_a), 32'h09);
    chk("both_wb_data", last_wb, 32'hDD5ABB11);
    chk("both_wb_cnt", wb_cnt, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
